// File: rtl/ws2812_pkg.sv
`timescale 1ns/1ps
// Shared WS2812B definitions: FSM states, wire colour-order codes and the
// time-to-cycle conversion used to size all bit and latch timers.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIT_HIGH,
    BIT_LOW,
    LATCH
  } state_t;

  localparam int ORDER_GRB = 0;
  localparam int ORDER_RGB = 1;

  localparam longint unsigned NS_PER_S = 64'd1_000_000_000;
  localparam longint unsigned US_PER_S = 64'd1_000_000;

  // floor(freq * t / per_sec), never below one cycle so every phase is visible
  function automatic int unsigned to_cycles(input longint unsigned freq,
                                            input longint unsigned t,
                                            input longint unsigned per_sec);
    longint unsigned c;
    c = (freq * t) / per_sec;
    if (c < 64'd1) c = 64'd1;
    return c[31:0];
  endfunction

endpackage

// File: rtl/ws2812_pixel_fmt.sv
`timescale 1ns/1ps
// Combinational pixel formatter: scales each {R,G,B} channel by (brightness+1)/256
// and reorders the result into the order the LEDs expect on the wire.
module ws2812_pixel_fmt
  import ws2812_pkg::*;
#(
  parameter int COLOR_ORDER = ORDER_GRB
) (
  input  logic [23:0] pixel,
  input  logic [7:0]  brightness,
  output logic [23:0] wire_word
);

  // 255 * 256 still fits in 16 bits, so no product bit is ever lost
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  logic [7:0] r, g, b;

  always_comb begin
    r = scale(pixel[23:16], brightness);
    g = scale(pixel[15:8],  brightness);
    b = scale(pixel[7:0],   brightness);
    wire_word = (COLOR_ORDER == ORDER_RGB) ? {r, g, b} : {g, r, b};
  end

endmodule

// File: rtl/ws2812b_chain_controller.sv
`timescale 1ns/1ps
// WS2812B chain driver: reads NUM_LEDS pixels through a one-cycle-latency port,
// prefetching the next pixel during the current one so the bit stream never stalls.
module ws2812b_chain_controller
  import ws2812_pkg::*;
#(
  parameter int SYS_FREQ    = 12_090_000,
  parameter int NUM_LEDS    = 6,
  parameter int COLOR_ORDER = 0,
  parameter int T0H_NS      = 400,
  parameter int T1H_NS      = 800,
  parameter int T0L_NS      = 850,
  parameter int T1L_NS      = 450,
  parameter int RESET_US    = 300,
  localparam int ADDR_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        brightness,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              busy,
  output logic              done,
  output logic              data_out
);

  localparam int unsigned T0H_C = to_cycles(64'(SYS_FREQ), 64'(T0H_NS), NS_PER_S);
  localparam int unsigned T1H_C = to_cycles(64'(SYS_FREQ), 64'(T1H_NS), NS_PER_S);
  localparam int unsigned T0L_C = to_cycles(64'(SYS_FREQ), 64'(T0L_NS), NS_PER_S);
  localparam int unsigned T1L_C = to_cycles(64'(SYS_FREQ), 64'(T1L_NS), NS_PER_S);
  localparam int unsigned RST_C = to_cycles(64'(SYS_FREQ), 64'(RESET_US), US_PER_S);

  localparam int unsigned MAX_H = (T0H_C > T1H_C) ? T0H_C : T1H_C;
  localparam int unsigned MAX_L = (T0L_C > T1L_C) ? T0L_C : T1L_C;
  localparam int unsigned MAX_B = (MAX_H > MAX_L) ? MAX_H : MAX_L;
  localparam int unsigned MAX_C = (MAX_B > RST_C) ? MAX_B : RST_C;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       hold_q, hold_d;
  logic [7:0]        bright_q, bright_d;
  logic              fetch_ph_q, fetch_ph_d;
  logic              cap_q, cap_d;
  logic              pix_rd_q, pix_rd_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              data_out_q, data_out_d;

  logic [23:0]       fmt_src, fmt_out;
  logic [ADDR_W-1:0] nxt_idx, nxt2_idx;

  // Pixel 0 is formatted straight off the read port; later pixels come from hold
  assign fmt_src  = (state_q == FETCH) ? pix_data : hold_q;
  assign nxt_idx  = pix_idx_q + ADDR_W'(1);
  assign nxt2_idx = nxt_idx + ADDR_W'(1);

  ws2812_pixel_fmt #(.COLOR_ORDER(COLOR_ORDER)) u_fmt (
    .pixel      (fmt_src),
    .brightness (bright_q),
    .wire_word  (fmt_out)
  );

  function automatic logic [CNT_W-1:0] hi_len(input logic b);
    return b ? CNT_W'(T1H_C - 1) : CNT_W'(T0H_C - 1);
  endfunction

  function automatic logic [CNT_W-1:0] lo_len(input logic b);
    return b ? CNT_W'(T1L_C - 1) : CNT_W'(T0L_C - 1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    pix_idx_d  = pix_idx_q;
    shift_d    = shift_q;
    hold_d     = cap_q ? pix_data : hold_q;
    bright_d   = bright_q;
    fetch_ph_d = fetch_ph_q;
    cap_d      = pix_rd_q;
    pix_rd_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          state_d    = FETCH;
          busy_d     = 1'b1;
          bright_d   = brightness;
          pix_rd_d   = 1'b1;
          pix_addr_d = '0;
          pix_idx_d  = '0;
          fetch_ph_d = 1'b0;
        end
      end

      FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          state_d    = BIT_HIGH;
          shift_d    = fmt_out;
          bit_idx_d  = '0;
          data_out_d = 1'b1;
          cnt_d      = hi_len(fmt_out[23]);
          if (pix_idx_q != LAST) begin
            pix_rd_d   = 1'b1;
            pix_addr_d = nxt_idx;
          end
        end
      end

      BIT_HIGH: begin
        if (cnt_q == '0) begin
          state_d    = BIT_LOW;
          data_out_d = 1'b0;
          cnt_d      = lo_len(shift_q[23]);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      BIT_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bit_idx_q != 5'd23) begin
          state_d    = BIT_HIGH;
          shift_d    = {shift_q[22:0], 1'b0};
          bit_idx_d  = bit_idx_q + 5'd1;
          data_out_d = 1'b1;
          cnt_d      = hi_len(shift_q[22]);
        end else if (pix_idx_q != LAST) begin
          // Back-to-back reload; the prefetch for the pixel after it goes out now
          state_d    = BIT_HIGH;
          pix_idx_d  = nxt_idx;
          shift_d    = fmt_out;
          bit_idx_d  = '0;
          data_out_d = 1'b1;
          cnt_d      = hi_len(fmt_out[23]);
          if (nxt_idx != LAST) begin
            pix_rd_d   = 1'b1;
            pix_addr_d = nxt2_idx;
          end
        end else begin
          state_d    = LATCH;
          data_out_d = 1'b0;
          cnt_d      = CNT_W'(RST_C - 1);
        end
      end

      LATCH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      pix_idx_q  <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      bright_q   <= '0;
      fetch_ph_q <= 1'b0;
      cap_q      <= 1'b0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      pix_idx_q  <= pix_idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      bright_q   <= bright_d;
      fetch_ph_q <= fetch_ph_d;
      cap_q      <= cap_d;
      pix_rd_q   <= pix_rd_d;
      pix_addr_q <= pix_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign pix_rd   = pix_rd_q;
  assign pix_addr = pix_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_ws2812b_chain_controller.sv
`timescale 1ns/1ps
// Bench for ws2812b_chain_controller: three instances (1 LED GRB, 3 LEDs GRB, 1 LED RGB)
// at 10 MHz, wire waveform decoded cycle by cycle against a queue of expected words.
module tb_ws2812b_chain_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_drv;
  int          sel;
  logic [7:0]  brightness;
  logic [23:0] mem [3];

  logic        st0, st1, st2;
  logic        rd0, rd1, rd2;
  logic [0:0]  a0, a2;
  logic [1:0]  a1;
  logic [23:0] pd0, pd1, pd2;
  logic        busy0, busy1, busy2, done0, done1, done2, do0, do1, do2;

  assign st0 = start_drv && (sel == 0);
  assign st1 = start_drv && (sel == 1);
  assign st2 = start_drv && (sel == 2);

  ws2812b_chain_controller #(.SYS_FREQ(10_000_000), .NUM_LEDS(1), .COLOR_ORDER(0), .RESET_US(50)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .brightness(brightness), .pix_rd(rd0), .pix_addr(a0),
    .pix_data(pd0), .busy(busy0), .done(done0), .data_out(do0));
  ws2812b_chain_controller #(.SYS_FREQ(10_000_000), .NUM_LEDS(3), .COLOR_ORDER(0), .RESET_US(50)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .brightness(brightness), .pix_rd(rd1), .pix_addr(a1),
    .pix_data(pd1), .busy(busy1), .done(done1), .data_out(do1));
  ws2812b_chain_controller #(.SYS_FREQ(10_000_000), .NUM_LEDS(1), .COLOR_ORDER(1), .RESET_US(50)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .brightness(brightness), .pix_rd(rd2), .pix_addr(a2),
    .pix_data(pd2), .busy(busy2), .done(done2), .data_out(do2));

  // Pixel memories: data valid the cycle after a read, garbage otherwise
  always @(posedge clk) begin
    pd0 <= rd0 ? mem[int'(a0)] : 24'hDEADBE;
    pd1 <= rd1 ? mem[int'(a1)] : 24'hDEADBE;
    pd2 <= rd2 ? mem[int'(a2)] : 24'hDEADBE;
  end

  logic c_do, c_busy, c_done, c_rd;
  int   c_addr;
  always_comb begin
    c_do = do0; c_busy = busy0; c_done = done0; c_rd = rd0; c_addr = int'(a0);
    if (sel == 1) begin
      c_do = do1; c_busy = busy1; c_done = done1; c_rd = rd1; c_addr = int'(a1);
    end else if (sel == 2) begin
      c_do = do2; c_busy = busy2; c_done = done2; c_rd = rd2; c_addr = int'(a2);
    end
  end

  typedef struct packed {
    logic [1:0]       sel;
    logic [7:0]       bright;
    logic [2:0][23:0] pix;
    logic [2:0][23:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [23:0] sb_q [$];
  int total = 0, bad = 0;
  int rd_cnt, addr_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (c_rd) begin
      if (c_addr != rd_cnt) addr_err++;
      rd_cnt++;
    end
  endtask

  task automatic run_frame(input vec_t v, input bit mid_start, input bit done_start);
    int n, b, c, shape_err, busy_err, latch_err, idle_busy;
    logic [23:0] word, exp_word, ref_word;
    n = (v.sel == 2'd1) ? 3 : 1;
    sel = int'(v.sel);
    for (int i = 0; i < 3; i++) mem[i] = v.pix[i];
    for (int i = 0; i < n; i++) sb_q.push_back(v.exp[i]);
    rd_cnt = 0; addr_err = 0; shape_err = 0; busy_err = 0; latch_err = 0;
    word = '0; ref_word = '0;
    brightness = v.bright;
    @(negedge clk);
    start_drv = 1'b1;
    tick();
    start_drv  = 1'b0;
    brightness = ~v.bright;
    chk("accept_busy", c_busy, 1);
    chk("first_rd", c_rd, 1);
    chk("first_addr", c_addr, 0);
    tick();
    chk("rd_one_cycle", c_rd, 0);
    chk("pre_rise_low", c_do, 0);
    tick();
    chk("first_rise", c_do, 1);
    for (int j = 0; j < n * 288; j++) begin
      b = (j / 12) % 24;
      c = j % 12;
      if (b == 0 && c == 0) begin
        ref_word  = (sb_q.size() != 0) ? sb_q[0] : 24'h0;
        word      = '0;
        shape_err = 0;
      end
      if (c_do !== (c < (ref_word[23 - b] ? 8 : 4))) shape_err++;
      if (c == 6) word = {word[22:0], c_do};
      if (c_busy !== 1'b1 || c_done !== 1'b0) busy_err++;
      if (mid_start) start_drv = (j == 100);
      if (b == 23 && c == 11) begin
        exp_word = sb_q.pop_front();
        chk("pixel_word", word, exp_word);
        chk("pixel_shape", shape_err, 0);
      end
      tick();
    end
    for (int l = 0; l < 500; l++) begin
      if (c_do !== 1'b0 || c_done !== 1'b0 || c_busy !== 1'b1) latch_err++;
      tick();
    end
    chk("latch_quiet", latch_err, 0);
    chk("busy_in_frame", busy_err, 0);
    chk("done_pulse", c_done, 1);
    chk("busy_on_done", c_busy, 1);
    if (done_start) start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    chk("done_once", c_done, 0);
    chk("busy_drop", c_busy, 0);
    idle_busy = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (c_busy !== 1'b0 || c_do !== 1'b0) idle_busy++;
    end
    chk("stays_idle", idle_busy, 0);
    chk("read_count", rd_cnt, n);
    chk("read_addrs", addr_err, 0);
  endtask

  initial begin
    int cnt;
    bit ok;
    rst_n = 1'b1; start_drv = 1'b0; sel = 0; brightness = 8'd0;
    rd_cnt = 0; addr_err = 0;
    for (int i = 0; i < 3; i++) mem[i] = 24'h0;

    vecs[0] = '{2'd0, 8'd255, {24'h0, 24'h0, 24'hFF0000}, {24'h0, 24'h0, 24'h00FF00}};
    vecs[1] = '{2'd0, 8'd127, {24'h0, 24'h0, 24'h804020}, {24'h0, 24'h0, 24'h204010}};
    vecs[2] = '{2'd2, 8'd255, {24'h0, 24'h0, 24'h123456}, {24'h0, 24'h0, 24'h123456}};
    vecs[3] = '{2'd1, 8'd255, {24'hA5C30F, 24'h445566, 24'h112233}, {24'hC3A50F, 24'h554466, 24'h221133}};
    vecs[4] = '{2'd1, 8'd0,   {24'h010203, 24'h808080, 24'hFFFFFF}, {24'h0, 24'h0, 24'h0}};
    vecs[5] = '{2'd0, 8'd128, {24'h0, 24'h0, 24'hFF8001}, {24'h0, 24'h0, 24'h408000}};
    vecs[6] = '{2'd2, 8'd1,   {24'h0, 24'h0, 24'hFF80FF}, {24'h0, 24'h0, 24'h010101}};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_dut0", {do0, busy0, done0, rd0, a0}, 0);
    chk("reset_dut1", {do1, busy1, done1, rd1, a1}, 0);
    chk("reset_dut2", {do2, busy2, done2, rd2, a2}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) run_frame(vecs[i], i == 3, i == 3);

    // start held through the done cycle re-triggers once IDLE is back
    sel = 0; mem[0] = 24'h00FF00; brightness = 8'd255;
    @(negedge clk);
    start_drv = 1'b1;
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      tick();
      if (c_done) ok = 1;
    end
    chk("held_first_done", ok, 1);
    tick();
    chk("held_gap", c_busy, 0);
    tick();
    chk("held_restart", c_busy, 1);
    start_drv = 1'b0;
    ok = 0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      tick();
      if (c_done) ok = 1;
    end
    chk("held_second_done", ok, 1);
    repeat (5) tick();

    // reset in the middle of bit 30 of a 3-pixel frame
    sel = 1; brightness = 8'd255;
    mem[0] = 24'hFFFFFF; mem[1] = 24'hFFFFFF; mem[2] = 24'hFFFFFF;
    @(negedge clk);
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    tick();
    tick();
    repeat (30 * 12 + 2) tick();
    chk("pre_reset_high", c_do, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_data_out", c_do, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_rd_addr", {c_rd, c_addr[1:0]}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (c_busy || c_done || c_do) cnt++;
    end
    chk("no_done_after_reset", cnt, 0);
    run_frame(vecs[3], 1'b0, 1'b0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
